// File: rtl/dcache_ecc_rmw_ctrl_if.sv
// Bundle of request/response handshakes, data-array port, ECC codec port and
// the error counter for the ECC read-modify-write sequencer.
// slave  : the sequencer side.
// master : the MSHR/store pipeline, SRAM and codec side.
interface dcache_ecc_rmw_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
);
    // request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_data;
    logic [DATA_W/8-1:0]   req_mask;
    // response channel
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_data;
    logic                  resp_corr;
    // data array port
    logic                  arr_en;
    logic                  arr_we;
    logic [ADDR_W-1:0]     arr_addr;
    logic [DATA_W-1:0]     arr_wdata;
    logic [DATA_W-1:0]     arr_rdata;
    // combinational encode/decode datapath
    logic [DATA_W-1:0]     enc_in;
    logic [DATA_W-1:0]     enc_out;
    logic [DATA_W-1:0]     dec_in;
    logic [DATA_W-1:0]     dec_data;
    logic                  dec_correctable;
    // status
    logic [15:0]           corr_count;

    modport slave (
        input  req_valid, req_write, req_addr, req_data, req_mask,
        output req_ready,
        output resp_valid, resp_data, resp_corr,
        input  resp_ready,
        output arr_en, arr_we, arr_addr, arr_wdata,
        input  arr_rdata,
        output enc_in, dec_in,
        input  enc_out, dec_data, dec_correctable,
        output corr_count
    );

    modport master (
        output req_valid, req_write, req_addr, req_data, req_mask,
        input  req_ready,
        input  resp_valid, resp_data, resp_corr,
        output resp_ready,
        input  arr_en, arr_we, arr_addr, arr_wdata,
        output arr_rdata,
        input  enc_in, dec_in,
        output enc_out, dec_data, dec_correctable,
        input  corr_count
    );
endinterface

// File: rtl/dcache_ecc_rmw_ctrl.sv
// ECC read-modify-write sequencer for the 128-bit data-cache data array.
// Handles one request at a time: reads (decode + correct), full writes
// (encode + write), byte-masked writes (read, merge, encode, write back).
// Optional feature macro ECC_SCRUB_EN: when defined, a read that hits a
// correctable error rewrites the corrected row before responding.
module dcache_ecc_rmw_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
) (
    input  logic clk,
    input  logic reset_n,
    dcache_ecc_rmw_ctrl_if.slave bus
);

    localparam int MASK_W = DATA_W / 8;

`ifdef ECC_SCRUB_EN
    localparam bit SCRUB_EN = 1'b1;
`else
    localparam bit SCRUB_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_WB,
        S_WR,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // latched request
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [MASK_W-1:0]   r_mask;

    // write-back payload, response and status
    logic [DATA_W-1:0]   r_wb_data;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_corr;
    logic [15:0]         r_corr_count;

    logic                w_accept;
    logic                w_full;
    logic                w_zero;
    logic [DATA_W-1:0]   w_merge;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_full   = &bus.req_mask;
    assign w_zero   = ~|bus.req_mask;

    // Byte merge of new write data over the corrected old row.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_merge = bus.dec_data;
        for (int i = 0; i < MASK_W; i++) begin
            if (r_mask[i]) begin
                w_merge[8*i +: 8] = r_data[8*i +: 8];
            end
        end
    end

    // State register; reset returns to IDLE asynchronously, killing any array access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (!bus.req_write)  w_next = S_RD;
                    else if (w_full)     w_next = S_WR;
                    else if (w_zero)     w_next = S_RESP;
                    else                 w_next = S_RD;
                end
            end
            S_RD:   w_next = S_CHK;
            S_CHK: begin
                if (r_write)                               w_next = S_WB;
                else if (bus.dec_correctable && SCRUB_EN)  w_next = S_WB;
                else                                       w_next = S_RESP;
            end
            S_WB:   w_next = S_RESP;
            S_WR:   w_next = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; array port is quiet outside RD/WR/WB.
    always_comb begin
        bus.req_ready  = (r_state == S_IDLE);
        bus.resp_valid = (r_state == S_RESP);
        bus.arr_en     = 1'b0;
        bus.arr_we     = 1'b0;
        bus.arr_addr   = '0;
        bus.arr_wdata  = '0;
        bus.enc_in     = '0;
        unique case (r_state)
            S_RD: begin
                bus.arr_en   = 1'b1;
                bus.arr_addr = r_addr;
            end
            S_WR: begin
                bus.arr_en    = 1'b1;
                bus.arr_we    = 1'b1;
                bus.arr_addr  = r_addr;
                bus.enc_in    = r_data;
                bus.arr_wdata = bus.enc_out;
            end
            S_WB: begin
                bus.arr_en    = 1'b1;
                bus.arr_we    = 1'b1;
                bus.arr_addr  = r_addr;
                bus.enc_in    = r_wb_data;
                bus.arr_wdata = bus.enc_out;
            end
            default: ;
        endcase
    end

    assign bus.dec_in     = bus.arr_rdata;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_corr  = r_resp_corr;
    assign bus.corr_count = r_corr_count;

    // Request latch, decode capture in CHK and the saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_mask       <= '0;
            r_wb_data    <= '0;
            r_resp_data  <= '0;
            r_resp_corr  <= 1'b0;
            r_corr_count <= '0;
        end else begin
            if (w_accept) begin
                r_write     <= bus.req_write;
                r_addr      <= bus.req_addr;
                r_data      <= bus.req_data;
                r_mask      <= bus.req_mask;
                r_resp_data <= '0;
                r_resp_corr <= 1'b0;
            end
            if (r_state == S_CHK) begin
                // partial writes push back the merge; scrub reads push back the corrected row
                r_wb_data <= r_write ? w_merge : bus.dec_data;
                if (!r_write) begin
                    r_resp_data <= bus.dec_data;
                    r_resp_corr <= bus.dec_correctable;
                end
                if (bus.dec_correctable && (r_corr_count != 16'hFFFF)) begin
                    r_corr_count <= r_corr_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_ecc_rmw_ctrl.sv
// Self-checking bench for dcache_ecc_rmw_ctrl: directed vector table,
// randomized traffic against a row-level reference model, and hand-written
// sequences for response back-pressure, counter saturation and mid-write reset.
module tb_dcache_ecc_rmw_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 128;
    localparam logic [127:0] KEY = 128'h5A3C96F00FF0A5C3_1234ABCD8765FEDC;

`ifdef ECC_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    dcache_ecc_rmw_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dcache_ecc_rmw_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // SRAM model, backdoor preload port and codec model (XOR "code" plus per-row error flag)
    logic [127:0] sram_mem [256];
    bit           sram_err [256];
    bit           rd_err;
    bit           bd_req = 1'b0;
    logic [7:0]   bd_a;
    logic [127:0] bd_d;
    bit           bd_e;

    assign bus.enc_out         = bus.enc_in ^ KEY;
    assign bus.dec_data        = bus.dec_in ^ KEY;
    assign bus.dec_correctable = rd_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.arr_en && !bus.arr_we) begin
            bus.arr_rdata <= sram_mem[bus.arr_addr];
            rd_err        <= sram_err[bus.arr_addr];
        end
        if (bus.arr_en && bus.arr_we) begin
            sram_mem[bus.arr_addr] <= bus.arr_wdata;
            sram_err[bus.arr_addr] <= 1'b0;
        end
        if (bd_req) begin
            sram_mem[bd_a] <= bd_d ^ KEY;
            sram_err[bd_a] <= bd_e;
        end
    end

    // Write monitor
    int         we_cnt = 0;
    int         we_at = 0;
    logic [7:0] we_addr = 8'h0;
    always @(negedge clk) begin
        if (bus.arr_en && bus.arr_we) begin
            we_cnt  = we_cnt + 1;
            we_at   = cyc;
            we_addr = bus.arr_addr;
        end
    end

    // Reference model: plain row contents, error flags and event count
    logic [127:0] ref_mem [256];
    bit           ref_err [256];
    logic [15:0]  ref_count = 16'h0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [127:0] d, input bit e);
        bd_a = a; bd_d = d; bd_e = e; bd_req = 1'b1;
        @(posedge clk);
        #1 bd_req = 1'b0;
    endtask

    function automatic logic [127:0] merge_bytes(input logic [127:0] old_row,
                                                 input logic [127:0] new_row,
                                                 input logic [15:0] m);
        logic [127:0] r;
        r = old_row;
        for (int b = 0; b < 16; b++) if (m[b]) r[8*b +: 8] = new_row[8*b +: 8];
        return r;
    endfunction

    task automatic bump();
        if (ref_count != 16'hFFFF) ref_count = ref_count + 16'd1;
    endtask

    task automatic model(input bit wr, input logic [7:0] a, input logic [127:0] d,
                         input logic [15:0] m, output int lat, output int nwr,
                         output logic [127:0] resp, output bit corr);
        resp = '0; corr = 1'b0; nwr = 0; lat = 1;
        if (!wr) begin
            resp = ref_mem[a];
            corr = ref_err[a];
            if (ref_err[a]) begin
                bump();
                if (SCRUB) begin nwr = 1; ref_err[a] = 1'b0; end
            end
            lat = (nwr != 0) ? 4 : 3;
        end else if (m == 16'hFFFF) begin
            lat = 2; nwr = 1; ref_mem[a] = d; ref_err[a] = 1'b0;
        end else if (m != 16'h0) begin
            if (ref_err[a]) bump();
            ref_mem[a] = merge_bytes(ref_mem[a], d, m);
            ref_err[a] = 1'b0;
            nwr = 1; lat = 4;
        end
    endtask

    task automatic do_txn(input bit wr, input logic [7:0] a, input logic [127:0] d,
                          input logic [15:0] m, input int hold,
                          output int lat, output int nwr, output int we_k,
                          output logic [7:0] we_a, output logic [127:0] rd, output bit rc);
        int c, w0, n;
        @(negedge clk);
        bus.resp_ready = (hold == 0);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.req_mask   = m;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) check("accept timeout", bus.req_ready, 1);
        c  = cyc;
        w0 = we_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 30);
        lat = bus.resp_valid ? (cyc - c) : -1;
        rd  = bus.resp_data;
        rc  = bus.resp_corr;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold resp_valid", bus.resp_valid, 1);
            check("hold resp_data", bus.resp_data, rd);
            check("hold req_ready", bus.req_ready, 0);
            check("hold arr_en", bus.arr_en, 0);
        end
        bus.resp_ready = 1'b1;
        if (bus.resp_valid) begin @(posedge clk); #1; end
        nwr  = we_cnt - w0;
        we_k = we_at - c;
        we_a = we_addr;
    endtask

    typedef struct {
        bit           wr;
        logic [7:0]   addr;
        logic [127:0] data;
        logic [15:0]  mask;
        bit           inj;
        logic [127:0] pre;
        int           lat;
        int           nwr;
        logic [127:0] resp;
        bit           corr;
        logic [127:0] row;
        int           cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, nwr, wk, elat, enwr, n;
        logic [7:0]   wa, a;
        logic [127:0] rd, erd, d;
        logic [15:0]  m;
        bit           rc, erc, wr;
        int           sel;

        vecs[0] = '{1'b1, 8'h12, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 1'b0, 128'h0,
                    2, 1, 128'h0, 1'b0, 128'h0123456789ABCDEF0123456789ABCDEF, 0};
        vecs[1] = '{1'b1, 8'h34, 128'hAA, 16'h0001, 1'b0, {16{8'h55}},
                    4, 1, 128'h0, 1'b0, {{15{8'h55}}, 8'hAA}, 0};
        vecs[2] = '{1'b0, 8'h40, 128'h0, 16'h0, 1'b0, 128'hDEADBEEFCAFEF00D123456789ABCDEF0,
                    3, 0, 128'hDEADBEEFCAFEF00D123456789ABCDEF0, 1'b0,
                    128'hDEADBEEFCAFEF00D123456789ABCDEF0, 0};
        vecs[3] = '{1'b0, 8'h41, 128'h0, 16'h0, 1'b1, {8{16'h1111}},
                    SCRUB ? 4 : 3, SCRUB ? 1 : 0, {8{16'h1111}}, 1'b1, {8{16'h1111}}, 1};
        vecs[4] = '{1'b1, 8'h50, {16{8'hFF}}, 16'h0000, 1'b0, {8{16'h2222}},
                    1, 0, 128'h0, 1'b0, {8{16'h2222}}, 1};
        vecs[5] = '{1'b1, 8'h60, {16{8'hCC}}, 16'hF0F0, 1'b1, {16{8'h33}},
                    4, 1, 128'h0, 1'b0, 128'hCCCCCCCC33333333CCCCCCCC33333333, 2};

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_mask   = '0;
        bus.resp_ready = 1'b1;

        // reset state
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst resp_valid", bus.resp_valid, 0);
        check("rst resp_data", bus.resp_data, 0);
        check("rst resp_corr", bus.resp_corr, 0);
        check("rst arr_en", bus.arr_en, 0);
        check("rst arr_we", bus.arr_we, 0);
        check("rst corr_count", bus.corr_count, 0);
        check("rst req_ready", bus.req_ready, 1);
        reset_n = 1'b1;

        // directed vectors
        for (int i = 0; i < 6; i++) begin
            preload(vecs[i].addr, vecs[i].pre, vecs[i].inj);
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, 0, lat, nwr, wk, wa, rd, rc);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d writes", i), nwr, vecs[i].nwr);
            check($sformatf("vec%0d resp_data", i), rd, vecs[i].resp);
            check($sformatf("vec%0d resp_corr", i), rc, vecs[i].corr);
            check($sformatf("vec%0d corr_count", i), bus.corr_count, vecs[i].cnt);
            check($sformatf("vec%0d row", i), sram_mem[vecs[i].addr] ^ KEY, vecs[i].row);
            if (vecs[i].nwr > 0) begin
                check($sformatf("vec%0d write cycle", i), wk, vecs[i].lat - 1);
                check($sformatf("vec%0d write addr", i), wa, vecs[i].addr);
            end
        end

        // fresh contents for randomized traffic
        ref_count = 16'd2;
        for (int r = 0; r < 256; r++) begin
            ref_mem[r] = {$urandom, $urandom, $urandom, $urandom};
            ref_err[r] = 1'b0;
            preload(r[7:0], ref_mem[r], 1'b0);
        end

        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                ref_err[a] = 1'b1;
                preload(a, ref_mem[a], 1'b1);
            end
            sel = $urandom_range(0, 9);
            wr  = (sel >= 4);
            d   = {$urandom, $urandom, $urandom, $urandom};
            if (sel < 4)       m = 16'h0;
            else if (sel < 6)  m = 16'hFFFF;
            else if (sel == 6) m = 16'h0;
            else               m = 16'($urandom);
            model(wr, a, d, m, elat, enwr, erd, erc);
            do_txn(wr, a, d, m, 0, lat, nwr, wk, wa, rd, rc);
            check($sformatf("rand%0d latency", i), lat, elat);
            check($sformatf("rand%0d writes", i), nwr, enwr);
            check($sformatf("rand%0d resp_data", i), rd, erd);
            check($sformatf("rand%0d resp_corr", i), rc, erc);
            check($sformatf("rand%0d corr_count", i), bus.corr_count, ref_count);
            if (enwr > 0) begin
                check($sformatf("rand%0d write addr", i), wa, a);
                check($sformatf("rand%0d row", i), sram_mem[a] ^ KEY, ref_mem[a]);
            end
        end

        // response back-pressure for 5 cycles
        model(1'b0, 8'h03, 128'h0, 16'h0, elat, enwr, erd, erc);
        do_txn(1'b0, 8'h03, 128'h0, 16'h0, 5, lat, nwr, wk, wa, rd, rc);
        check("hold resp_data value", rd, erd);
        check("hold corr_count", bus.corr_count, ref_count);

        // counter saturation near the top of its range
        @(negedge clk);
        force dut.r_corr_count = 16'hFFFD;
        #1 release dut.r_corr_count;
        ref_count = 16'hFFFD;
        for (int k = 0; k < 3; k++) begin
            ref_err[8'h05] = 1'b1;
            preload(8'h05, ref_mem[8'h05], 1'b1);
            model(1'b0, 8'h05, 128'h0, 16'h0, elat, enwr, erd, erc);
            do_txn(1'b0, 8'h05, 128'h0, 16'h0, 0, lat, nwr, wk, wa, rd, rc);
            check($sformatf("sat%0d resp_corr", k), rc, 1);
            check($sformatf("sat%0d resp_data", k), rd, erd);
            check($sformatf("sat%0d corr_count", k), bus.corr_count, ref_count);
        end
        check("sat final", bus.corr_count, 16'hFFFF);

        // reset asserted while a partial-write write-back is on the array port
        preload(8'h77, {8{16'hBEEF}}, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h77;
        bus.req_data  = {16{8'h11}};
        bus.req_mask  = 16'h00FF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arr_we && n < 10);
        check("rst wb reached", bus.arr_we, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst async arr_we", bus.arr_we, 0);
        check("rst async arr_en", bus.arr_en, 0);
        check("rst mid resp_valid", bus.resp_valid, 0);
        check("rst mid corr_count", bus.corr_count, 0);
        check("rst mid req_ready", bus.req_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst req_ready", bus.req_ready, 1);
        check("post rst resp_valid", bus.resp_valid, 0);
        check("post rst row kept", sram_mem[8'h77] ^ KEY, {8{16'hBEEF}});
        ref_count       = 16'h0;
        ref_mem[8'h77]  = {8{16'hBEEF}};
        ref_err[8'h77]  = 1'b0;
        model(1'b0, 8'h77, 128'h0, 16'h0, elat, enwr, erd, erc);
        do_txn(1'b0, 8'h77, 128'h0, 16'h0, 0, lat, nwr, wk, wa, rd, rc);
        check("post rst read latency", lat, elat);
        check("post rst read data", rd, erd);
        check("post rst corr_count", bus.corr_count, ref_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_ecc_rmw_ctrl.md
# dcache_ecc_rmw_ctrl

Sequencer for the ECC-protected 128-bit data-array port of the non-blocking data cache. It accepts one request at a time (read, full write or byte-masked write) and drives the single-port data SRAM. It routes data through the external encode/decode datapath, performing read-modify-write for partial writes and optional scrub write-back of correctable errors. It sits between the MSHR/store pipeline and the data array, and owns all accesses to that array.

## Interface
- ADDR_W, 8, data-array row index width
- DATA_W, 128, row width; mask width is DATA_W/8 = 16
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  request handshake; transfer when both high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  row index
- req_data  in  DATA_W  write data
- req_mask  in  16  byte enables, bit i covers bits [8i+7:8i]
- resp_valid / resp_ready  out / in  1  response handshake
- resp_data  out  DATA_W  corrected read data; 0 for writes
- resp_corr  out  1  read hit a correctable error
- arr_en, arr_we  out  1  SRAM enable, write enable
- arr_addr  out  ADDR_W  SRAM row
- arr_wdata  out  DATA_W  encoded write data
- arr_rdata  in  DATA_W  SRAM read data, valid the cycle after arr_en && !arr_we
- enc_in / enc_out  out / in  DATA_W  combinational encoder port
- dec_in  out  DATA_W  decoder input
- dec_data / dec_correctable  in  DATA_W / 1  corrected data and flag from the combinational decoder
- corr_count  out  16  saturating count of correctable events

## Operation
- States: IDLE, RD, CHK, WB, WR, RESP. req_ready = (state == IDLE).
- Request fields are latched on accept. dec_in = arr_rdata. enc_in = full data (WR), merged data (partial WB), or dec_data (scrub WB).
- Read: IDLE -> RD (arr_en) -> CHK.
  - In CHK, latch dec_data and dec_correctable.
  - If correctable and scrub is enabled: -> WB. Otherwise: -> RESP.
- Full write (mask = 0xFFFF): IDLE -> WR (arr_en, arr_we, arr_wdata = enc_out(req_data)) -> RESP.
- Partial write (mask nonzero, not all ones): IDLE -> RD -> CHK, where merge = mask ? req_data : dec_data per byte -> WB (write enc_out(merge)) -> RESP.
- Zero-mask write: IDLE -> RESP. No array access.
- RESP: hold resp_valid and resp_data/resp_corr stable until resp_ready, then -> IDLE.
- corr_count increments by 1 in every CHK cycle with dec_correctable = 1, for reads and partial writes alike. It saturates at 0xFFFF with no wrap.
- The arr_* outputs are 0 in every state other than RD, WR and WB.

## Timing
- Accept at cycle T. Responses assume resp_ready = 1:
  - full write: array write at T+1, resp_valid at T+2
  - clean read: read at T+1, CHK at T+2, resp_valid at T+3
  - scrub read and partial write: write-back at T+3, resp_valid at T+4
  - zero mask: resp_valid at T+1
- Back-to-back throughput: the next accept can occur in the cycle after the resp handshake.
- Reset values: state IDLE, resp_valid 0, resp_data 0, resp_corr 0, arr_en 0, arr_we 0, corr_count 0.
- Reset asserted mid-operation takes effect immediately:
  - arr_en and arr_we drop asynchronously, so a pending WB/WR is abandoned.
  - Latched request and response state is discarded.
- A correctable error on a partial write always writes back merged data. Partial writes have a write-back regardless of scrub; resp_corr = 0 for writes.

## Configuration
- ECC_SCRUB_EN defined: a read with dec_correctable = 1 goes CHK -> WB, rewriting enc_out(dec_data) to the same row, then RESP.
- ECC_SCRUB_EN undefined: such a read goes CHK -> RESP with no write-back. resp_corr and corr_count still report the error.

## Test plan
- Full write, addr 0x12, data 0x0123..EF, mask 0xFFFF -> exactly one arr_we at T+1 with addr 0x12; resp_valid at T+2 with resp_data 0.
- Partial write, mask 0x0001, data 0xAA, stored row 0x55..55 -> RD at T+1, write at T+3 of 0x55..55AA; resp at T+4.
- Read with codec model asserting dec_correctable -> resp_corr = 1 and corr_count 0 -> 1.
  - ECC_SCRUB_EN defined: write-back at T+3 and resp at T+4.
  - ECC_SCRUB_EN undefined: no arr_we, and resp at T+3.
- Hold resp_ready = 0 for 5 cycles -> resp_valid/resp_data stable, req_ready = 0, and no array activity.
- Preload corr_count at 0xFFFF via repeated correctable reads -> stays at 0xFFFF.
- Assert reset_n low during WB -> arr_we falls without waiting for a clock edge. After release: state IDLE, resp_valid 0, corr_count 0, and req_ready = 1 on the first clock.
